// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Definitions shared by the multiply/divide unit and its issue controller, so
// that both ends of the start/busy handshake agree on op codes, latencies and
// the issue-controller state encoding.
// ---------------------------------------------------------------------------
package mdu_pkg;

   // Operation codes carried on MDUOp; bit 1 distinguishes divide from multiply
   typedef enum logic [2:0] {
      MDU_MULU = 3'b000,
      MDU_MUL  = 3'b001,
      MDU_DIVU = 3'b010,
      MDU_DIV  = 3'b011
   } mdu_op_e;

   // Busy-cycle counts of the MDU and the mirror counter width that holds them
   localparam int MUL_LAT_DEF = 5;
   localparam int DIV_LAT_DEF = 10;
   localparam int CW_DEF      = 4;

   // Issue controller states: nothing outstanding / one operation in flight
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } issue_st_e;

   // Divides are the ops with bit 1 set; they take the long latency
   function automatic logic op_is_div(input logic [2:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/md_lat_mirror.sv
// ---------------------------------------------------------------------------
// md_lat_mirror
// Local copy of the MDU latency: a loadable down-counter that runs while an
// operation is in flight, plus a comparator against the MDU's busy output.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   load         launch this cycle; counter takes load_val at the next edge
//   load_val     latency of the launched operation
//   mdu_busy     busy flag coming back from the MDU
//   ctr_nz       counter non-zero (operation still outstanding)
//   ctr_last     counter equals 1 (final busy cycle)
//   mismatch     MDU busy disagrees with the mirror in a non-reset cycle
// ---------------------------------------------------------------------------
module md_lat_mirror #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          mdu_busy,
   output logic          ctr_nz,
   output logic          ctr_last,
   output logic          mismatch
);

   logic [CW-1:0] ctr;

   // The counter only ever decrements from a non-zero value, so it cannot wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         ctr <= '0;
      end else if (load) begin
         ctr <= load_val;
      end else if (ctr != '0) begin
         ctr <= ctr - CW'(1);
      end
   end

   assign ctr_nz   = (ctr != '0);
   assign ctr_last = (ctr == CW'(1));
   assign mismatch = ~reset & (mdu_busy != ctr_nz);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl
// Initiator side of the start/busy multiply-divide handshake at the D/E
// boundary. Launches mult/div and mthi/mtlo from E into the MDU, stalls D-stage
// MDU users while an operation is in flight, suppresses launches when an
// interrupt flushes E, and flags any disagreement with the MDU's busy timing.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   IntReq        interrupt/exception taken; E-stage instruction is flushed
//   e_md_valid    E holds mult/multu/div/divu, op code on e_md_op
//   e_mthi        E holds mthi
//   e_mtlo        E holds mtlo
//   d_md_use      D holds an instruction that touches the MDU or HI/LO
//   mdu_busy      busy flag from the MDU
//   start         launch pulse to the MDU
//   MDUOp         op code to the MDU, zero when not launching
//   HIWrite       write HI from operand A
//   LOWrite       write LO from operand A
//   stall         freeze PC/D and bubble into E
//   proto_err     sticky handshake-mismatch flag, cleared only by reset
// ---------------------------------------------------------------------------
module mdu_issue_ctrl
   import mdu_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF,
   parameter int CW      = CW_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       IntReq,
   input  logic       e_md_valid,
   input  logic [2:0] e_md_op,
   input  logic       e_mthi,
   input  logic       e_mtlo,
   input  logic       d_md_use,
   input  logic       mdu_busy,
   output logic       start,
   output logic [2:0] MDUOp,
   output logic       HIWrite,
   output logic       LOWrite,
   output logic       stall,
   output logic       proto_err
);

   // Latencies must be non-zero and fit the mirror counter
   if (MUL_LAT < 1 || MUL_LAT >= (1 << CW)) begin : g_bad_mul_lat
      $error("mdu_issue_ctrl: MUL_LAT must be >= 1 and < 2**CW");
   end
   if (DIV_LAT < 1 || DIV_LAT >= (1 << CW)) begin : g_bad_div_lat
      $error("mdu_issue_ctrl: DIV_LAT must be >= 1 and < 2**CW");
   end

   issue_st_e     st;
   issue_st_e     st_next;
   logic          launch;
   logic [CW-1:0] lat_val;
   logic          ctr_nz;
   logic          ctr_last;
   logic          mismatch;
   logic          multi_src;
   logic          leak;

   assign lat_val = op_is_div(e_md_op) ? CW'(DIV_LAT) : CW'(MUL_LAT);

   md_lat_mirror #(
      .CW(CW)
   ) u_mirror (
      .clk      (clk),
      .reset    (reset),
      .load     (launch),
      .load_val (lat_val),
      .mdu_busy (mdu_busy),
      .ctr_nz   (ctr_nz),
      .ctr_last (ctr_last),
      .mismatch (mismatch)
   );

   // State register; reset abandons any outstanding op because the MDU is
   // reset by the same signal
   always_ff @(posedge clk) begin
      if (reset) begin
         st <= ST_IDLE;
      end else begin
         st <= st_next;
      end
   end

   // Next state and output decode. Everything is held low during reset.
   // The launch cycle already stalls D because MDU busy only rises at the
   // next edge. Leaving WAIT on an unexpectedly empty counter keeps the FSM
   // from locking up should the two ever disagree.
   always_comb begin
      st_next = st;
      launch  = 1'b0;
      HIWrite = 1'b0;
      LOWrite = 1'b0;
      stall   = 1'b0;
      if (!reset) begin
         case (st)
            ST_IDLE: begin
               launch  = e_md_valid & ~IntReq;
               HIWrite = e_mthi & ~e_md_valid & ~IntReq;
               LOWrite = e_mtlo & ~e_md_valid & ~e_mthi & ~IntReq;
               stall   = d_md_use & launch;
               if (launch) begin
                  st_next = ST_WAIT;
               end
            end
            ST_WAIT: begin
               stall = d_md_use;
               if (ctr_last || !ctr_nz) begin
                  st_next = ST_IDLE;
               end
            end
            default: begin
               st_next = ST_IDLE;
            end
         endcase
      end
   end

   assign start = launch;
   assign MDUOp = launch ? e_md_op : 3'b000;

   // Only one MDU source may be present in E at a time, and none may reach E
   // while an op is outstanding (that would mean the stall leaked)
   assign multi_src = (e_md_valid & e_mthi) | (e_md_valid & e_mtlo) | (e_mthi & e_mtlo);
   assign leak      = (st == ST_WAIT) & (e_md_valid | e_mthi | e_mtlo);

   // Sticky protocol error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         proto_err <= 1'b0;
      end else if (multi_src || leak || mismatch) begin
         proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_issue_ctrl
// Bench for mdu_issue_ctrl paired with a behavioural MDU. Expected outputs come
// from a cycle-number model: an operation launched in cycle c occupies the MDU
// until cycle c+1+latency.
// ---------------------------------------------------------------------------
module tb_mdu_issue_ctrl;
   import mdu_pkg::*;

   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       IntReq;
   logic       e_md_valid;
   logic [2:0] e_md_op;
   logic       e_mthi;
   logic       e_mtlo;
   logic       d_md_use;
   logic       mdu_busy;
   logic       start;
   logic [2:0] MDUOp;
   logic       HIWrite;
   logic       LOWrite;
   logic       stall;
   logic       proto_err;

   int errors = 0;
   int checks = 0;

   // Behavioural MDU: busy for the op's latency after each start pulse
   int mduCnt = 0;
   bit tieBusyLow = 1'b0;

   // Reference model state
   int cyc = 0;
   int endCyc = 0;
   bit errModel = 1'b0;
   int stallCycles = 0;

   always #5 clk = ~clk;

   mdu_issue_ctrl #(
      .MUL_LAT(MUL_LAT),
      .DIV_LAT(DIV_LAT),
      .CW(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .IntReq     (IntReq),
      .e_md_valid (e_md_valid),
      .e_md_op    (e_md_op),
      .e_mthi     (e_mthi),
      .e_mtlo     (e_mtlo),
      .d_md_use   (d_md_use),
      .mdu_busy   (mdu_busy),
      .start      (start),
      .MDUOp      (MDUOp),
      .HIWrite    (HIWrite),
      .LOWrite    (LOWrite),
      .stall      (stall),
      .proto_err  (proto_err)
   );

   // MDU counterpart, reset by the same signal as the controller
   always @(posedge clk) begin
      if (reset) begin
         mduCnt <= 0;
      end else if (start) begin
         mduCnt <= MDUOp[1] ? DIV_LAT : MUL_LAT;
      end else if (mduCnt > 0) begin
         mduCnt <= mduCnt - 1;
      end
   end

   assign mdu_busy = (mduCnt != 0) && !tieBusyLow;

   task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit iq, input bit v, input logic [2:0] op,
                                input bit hi, input bit lo, input bit du);
      reset      = r;
      IntReq     = iq;
      e_md_valid = v;
      e_md_op    = op;
      e_mthi     = hi;
      e_mtlo     = lo;
      d_md_use   = du;
   endtask

   // Compare all outputs with the model, then advance the model by one cycle
   task automatic checkOutput();
      bit idle;
      bit expLaunch;
      bit expHi;
      bit expLo;
      bit expStall;
      int nsrc;
      idle      = (cyc >= endCyc);
      expLaunch = !reset && idle && e_md_valid && !IntReq;
      expHi     = !reset && idle && e_mthi && !e_md_valid && !IntReq;
      expLo     = !reset && idle && e_mtlo && !e_md_valid && !e_mthi && !IntReq;
      expStall  = !reset && d_md_use && (expLaunch || !idle);
      checkValue("start", 8'(start), 8'(expLaunch));
      checkValue("MDUOp", 8'(MDUOp), expLaunch ? 8'(e_md_op) : 8'h00);
      checkValue("HIWrite", 8'(HIWrite), 8'(expHi));
      checkValue("LOWrite", 8'(LOWrite), 8'(expLo));
      checkValue("stall", 8'(stall), 8'(expStall));
      checkValue("proto_err", 8'(proto_err), 8'(errModel));
      if (stall === 1'b1) stallCycles++;
      if (reset) begin
         errModel = 1'b0;
         endCyc   = cyc + 1;
      end else begin
         nsrc = int'(e_md_valid) + int'(e_mthi) + int'(e_mtlo);
         if (nsrc > 1 || (!idle && nsrc > 0) || (mdu_busy != !idle)) errModel = 1'b1;
         if (expLaunch) endCyc = cyc + 1 + (e_md_op[1] ? DIV_LAT : MUL_LAT);
      end
      cyc++;
   endtask

   task automatic stepCycle(input bit r, input bit iq, input bit v, input logic [2:0] op,
                            input bit hi, input bit lo, input bit du);
      applyStimulus(r, iq, v, op, hi, lo, du);
      #1;
      checkOutput();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idleSteps(input int n, input bit du);
      for (int i = 0; i < n; i++) stepCycle(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, du);
   endtask

   task automatic randomStep();
      bit r, iq, v, hi, lo, du;
      logic [2:0] op;
      int kind;
      r  = ($urandom_range(0, 39) == 0);
      iq = ($urandom_range(0, 7) == 0);
      du = 1'(($urandom_range(0, 1)));
      op = 3'($urandom_range(0, 3));
      v = 1'b0; hi = 1'b0; lo = 1'b0;
      if (cyc >= endCyc || $urandom_range(0, 29) == 0) begin
         kind = $urandom_range(0, 6);
         case (kind)
            0, 1: v = 1'b1;
            2: hi = 1'b1;
            3: lo = 1'b1;
            4: begin
               v  = 1'(($urandom_range(0, 1)));
               hi = 1'(($urandom_range(0, 1)));
               lo = 1'(($urandom_range(0, 1)));
            end
            default: ;
         endcase
      end
      stepCycle(r, iq, v, op, hi, lo, du);
   endtask

   initial begin
      // Power-up: one unchecked reset cycle establishes known state
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      stepCycle(1'b1, 1'b0, 1'b1, MDU_MUL, 1'b1, 1'b0, 1'b1);
      idleSteps(2, 1'b0);

      // MULT with mflo held in D
      $display("[TB] mult");
      stallCycles = 0;
      stepCycle(1'b0, 1'b0, 1'b1, MDU_MUL, 1'b0, 1'b0, 1'b1);
      idleSteps(6, 1'b1);
      checkValue("mult_stall_len", 8'(stallCycles), 8'd6);
      checkValue("mult_proto_err", 8'(proto_err), 8'd0);

      // DIVU with mfhi in D
      $display("[TB] divu");
      stallCycles = 0;
      stepCycle(1'b0, 1'b0, 1'b1, MDU_DIVU, 1'b0, 1'b0, 1'b1);
      idleSteps(11, 1'b1);
      checkValue("divu_stall_len", 8'(stallCycles), 8'd11);

      // Interrupt on the launch cycle
      $display("[TB] interrupt on launch");
      stepCycle(1'b0, 1'b1, 1'b1, MDU_MULU, 1'b0, 1'b0, 1'b1);
      checkValue("int_mdu_busy", 8'(mdu_busy), 8'd0);
      idleSteps(2, 1'b1);

      // Interrupt during WAIT has no effect
      stepCycle(1'b0, 1'b0, 1'b1, MDU_MULU, 1'b0, 1'b0, 1'b1);
      stepCycle(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
      idleSteps(5, 1'b1);

      // Reset in cycle 3 of a DIV, then a fresh MUL at cycle 5
      $display("[TB] reset mid-op");
      stepCycle(1'b0, 1'b0, 1'b1, MDU_DIV, 1'b0, 1'b0, 1'b1);
      idleSteps(2, 1'b1);
      stepCycle(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
      idleSteps(1, 1'b1);
      stallCycles = 0;
      stepCycle(1'b0, 1'b0, 1'b1, MDU_MUL, 1'b0, 1'b0, 1'b1);
      idleSteps(6, 1'b1);
      checkValue("remul_stall_len", 8'(stallCycles), 8'd6);

      // mthi / mtlo alone, then mthi with mult together
      $display("[TB] mthi/mtlo");
      stepCycle(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
      stepCycle(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      stepCycle(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      idleSteps(1, 1'b0);
      stepCycle(1'b0, 1'b0, 1'b1, MDU_MULU, 1'b1, 1'b0, 1'b0);
      idleSteps(7, 1'b0);
      checkValue("multi_src_sticky", 8'(proto_err), 8'd1);
      stepCycle(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      stepCycle(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
      idleSteps(2, 1'b0);
      stepCycle(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

      // MDU busy stuck low
      $display("[TB] busy mismatch");
      tieBusyLow = 1'b1;
      stepCycle(1'b0, 1'b0, 1'b1, MDU_MUL, 1'b0, 1'b0, 1'b1);
      idleSteps(7, 1'b1);
      checkValue("mismatch_sticky", 8'(proto_err), 8'd1);
      tieBusyLow = 1'b0;
      stepCycle(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

      // Randomized traffic against the model
      $display("[TB] random traffic");
      for (int i = 0; i < 800; i++) randomStep();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
